// File: rtl/code_sender_if.sv
// code_sender_if: groups the controller handshake and the lock-side signals
// of code_sender into one bundle.
//   slave  : the code_sender itself (consumes start/code_word/locked/selsw,
//            drives out/out_valid/busy/done/status)
//   master : the environment (controller plus lock) on the other side
interface code_sender_if #(
  parameter int DIGIT_W = 3
) ();
  logic                   start;      // request a send
  logic [4*DIGIT_W-1:0]   code_word;  // digit0 in LSBs, digit3 in MSBs
  logic                   locked;     // lock status, 0 = unlocked
  logic [1:0]             selsw;      // lock position indicator
  logic [DIGIT_W-1:0]     out;        // digit driven to the lock
  logic                   out_valid;  // out carries a code digit
  logic                   busy;       // operation in progress
  logic                   done;       // one-cycle completion pulse
  logic [1:0]             status;     // 00 none, 01 ok, 10 timeout, 11 desync

  modport master (
    output start, code_word, locked, selsw,
    input  out, out_valid, busy, done, status
  );

  modport slave (
    input  start, code_word, locked, selsw,
    output out, out_valid, busy, done, status
  );
endinterface

// File: rtl/code_sender.sv
// code_sender: transmit side of a 4-digit sequential lock. Latches a code
// word on start, drives one digit per clock to the lock while checking the
// lock's position indicator, then waits a bounded time for the lock to open.
// A timeout is retried RETRIES times with GAP idle cycles in between.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - code_sender_if.slave (start, code_word, locked, selsw in;
//           out, out_valid, busy, done, status out; all outputs registered)
module code_sender #(
  parameter int DIGIT_W  = 3,
  parameter int MAX_WAIT = 15,
  parameter int RETRIES  = 2,
  parameter int GAP      = 12
) (
  input  logic          clk,
  input  logic          reset,
  code_sender_if.slave  bus
);

  localparam int WCNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int GCNT_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam int ATT_W  = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP_WAIT,
    S_FINISH
  } state_t;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_OK      = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_DESYNC  = 2'b11;

  state_t                 state;
  logic [4*DIGIT_W-1:0]   code_q;
  logic [1:0]             idx;
  logic [ATT_W-1:0]       att;
  logic [WCNT_W-1:0]      wcnt;
  logic [GCNT_W-1:0]      gcnt;

  function automatic logic [DIGIT_W-1:0] digit_of(input logic [4*DIGIT_W-1:0] word,
                                                  input logic [1:0] i);
    return word[int'(i)*DIGIT_W +: DIGIT_W];
  endfunction

  // Outputs are computed for the state being entered, so out/out_valid show
  // digit0 in the very first SEND cycle and every output stays registered.
  // NOTE: all state, including the latched code word, uses non-blocking
  // assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every register, the code copy included, is cleared by the
      // asynchronous reset so a mid-operation reset leaves nothing behind.
      state         <= S_IDLE;
      code_q        <= '0;
      idx           <= '0;
      att           <= '0;
      wcnt          <= '0;
      gcnt          <= '0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.status    <= ST_NONE;
    end else begin
      bus.done <= 1'b0;  // pulse is only raised on the transition into FINISH

      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            code_q        <= bus.code_word;
            bus.status    <= ST_NONE;
            idx           <= '0;
            att           <= '0;
            bus.out       <= bus.code_word[DIGIT_W-1:0];
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= S_SEND;
          end
        end

        S_SEND: begin
          if (bus.selsw != idx) begin
            // Lock position disagrees with ours: give up without retrying.
            bus.status    <= ST_DESYNC;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b1;
            state         <= S_FINISH;
          end else if (idx == 2'd3) begin
            wcnt          <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            state         <= S_WAIT;
          end else begin
            idx     <= idx + 2'd1;
            bus.out <= digit_of(code_q, idx + 2'd1);
          end
        end

        S_WAIT: begin
          // Unlock is tested first so it wins over a same-cycle timeout.
          if (!bus.locked) begin
            bus.status <= ST_OK;
            bus.done   <= 1'b1;
            state      <= S_FINISH;
          end else if (wcnt == WCNT_W'(MAX_WAIT - 1)) begin
            if (att < ATT_W'(RETRIES)) begin
              att   <= att + 1'b1;
              gcnt  <= '0;
              state <= S_GAP_WAIT;
            end else begin
              bus.status <= ST_TIMEOUT;
              bus.done   <= 1'b1;
              state      <= S_FINISH;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        S_GAP_WAIT: begin
          if (gcnt == GCNT_W'(GAP - 1)) begin
            idx           <= '0;
            bus.out       <= code_q[DIGIT_W-1:0];
            bus.out_valid <= 1'b1;
            state         <= S_SEND;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end

        S_FINISH: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_sender.sv
// tb_code_sender: self-checking bench for code_sender. A behavioural lock
// (secret 0,1,2,3, configurable unlock delay) answers the sender; a table of
// directed vectors, hand-written reset / held-start sequences and random
// operations are compared against expectations derived from the lock rules.
module tb_code_sender;

  localparam int DIGIT_W  = 3;
  localparam int MAX_WAIT = 15;
  localparam int RETRIES  = 2;
  localparam int GAP      = 12;
  localparam int NEVER    = 1000;
  localparam int T_OUT    = 1 + (RETRIES + 1) * (4 + MAX_WAIT) + RETRIES * GAP;

  logic clk;
  logic reset;

  code_sender_if #(.DIGIT_W(DIGIT_W)) bus ();

  code_sender #(
    .DIGIT_W (DIGIT_W),
    .MAX_WAIT(MAX_WAIT),
    .RETRIES (RETRIES),
    .GAP     (GAP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural lock ----------------
  int secret [4] = '{0, 1, 2, 3};
  int lk_pos    = 0;
  bit lk_wrong  = 1'b0;
  bit lk_armed  = 1'b0;
  int lk_cd     = 0;
  bit lk_locked = 1'b1;
  int lk_delay  = 0;   // cycles after the first WAIT cycle before unlocking

  // Decides at the falling edge, presents the result just after the next
  // rising edge: behaves like a registered lock.
  initial begin : lock_proc
    bus.locked = 1'b1;
    bus.selsw  = 2'd0;
    forever begin
      @(negedge clk);
      if (!bus.busy) begin
        lk_pos = 0; lk_wrong = 1'b0; lk_armed = 1'b0; lk_locked = 1'b1;
      end else if (bus.out_valid) begin
        lk_armed  = 1'b0;
        lk_locked = 1'b1;
        if (!lk_wrong && int'(bus.out) == secret[lk_pos]) begin
          if (lk_pos == 3) begin
            lk_pos   = 0;
            lk_armed = 1'b1;
            lk_cd    = lk_delay;
            if (lk_cd == 0) lk_locked = 1'b0;
          end else begin
            lk_pos++;
          end
        end else begin
          lk_wrong = 1'b1;
          lk_pos   = 0;
        end
      end else begin
        lk_wrong = 1'b0;
        if (lk_armed && lk_locked) begin
          if (lk_cd > 0) lk_cd--;
          if (lk_cd == 0) lk_locked = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      bus.selsw  = 2'(lk_pos);
      bus.locked = lk_locked;
    end
  end

  // ---------------- reference model ----------------
  // Outcome of one operation against the lock above, from the protocol rules:
  // first wrong digit j<3 is seen as desync one SEND cycle later; a wrong last
  // digit or a late unlock exhausts all attempts.
  function automatic void ref_model(input logic [11:0] code, input int delay,
                                    output logic [1:0] st, output int lat, output int ov);
    int j = 4;
    for (int i = 3; i >= 0; i--)
      if (int'(code[i*DIGIT_W +: DIGIT_W]) != secret[i]) j = i;
    if (j < 3) begin
      st = 2'b11; lat = j + 3; ov = j + 2;
    end else if (j == 4 && delay < MAX_WAIT) begin
      st = 2'b01; lat = 6 + delay; ov = 4;
    end else begin
      st = 2'b10; lat = T_OUT; ov = 4 * (RETRIES + 1);
    end
  endfunction

  // ---------------- one complete operation ----------------
  task automatic run_op(input string tag, input logic [11:0] code, input int delay,
                        input logic [1:0] exp_st, input int exp_lat, input int exp_ov);
    int lat    = 1;
    int ov_cnt = 0;
    int bad    = 0;
    bit idle_seen = 1'b0;
    lk_delay = delay;
    @(negedge clk);
    bus.code_word = code;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.code_word = ~code;  // only the latched copy may be used from here on
    check({tag, " status_cleared"}, 32'(bus.status), 32'd0);
    while (!bus.done && lat < 200) begin
      if (bus.out_valid) begin
        if (bus.out !== code[(ov_cnt % 4) * DIGIT_W +: DIGIT_W]) bad++;
        ov_cnt++;
      end
      if (!bus.busy) idle_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " done_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " status"}, 32'(bus.status), 32'(exp_st));
    check({tag, " out_valid_cycles"}, 32'(ov_cnt), 32'(exp_ov));
    check({tag, " digit_errors"}, 32'(bad), 32'd0);
    check({tag, " busy_gap"}, 32'(idle_seen), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, " idle_after"}, 32'(bus.busy), 32'd0);
    check({tag, " status_held"}, 32'(bus.status), 32'(exp_st));
  endtask

  typedef struct {
    logic [11:0] code;
    int          delay;
    logic [1:0]  st;
    int          lat;
    int          ov;
  } vec_t;

  vec_t vecs [9];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [1:0]  r_st;
    int          r_lat;
    int          r_ov;
    logic [11:0] r_code;
    int          r_delay;
    int          lat;

    vecs[0] = '{12'o3210, 0,     2'b01, 6,     4};
    vecs[1] = '{12'o3213, 0,     2'b11, 3,     2};
    vecs[2] = '{12'o3200, 0,     2'b11, 4,     3};
    vecs[3] = '{12'o3010, 0,     2'b11, 5,     4};
    vecs[4] = '{12'o0210, 0,     2'b10, 82,    12};
    vecs[5] = '{12'o3210, NEVER, 2'b10, 82,    12};
    vecs[6] = '{12'o3210, 14,    2'b01, 20,    4};
    vecs[7] = '{12'o3210, 15,    2'b10, 82,    12};
    vecs[8] = '{12'o3210, 5,     2'b01, 11,    4};

    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.code_word = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out",       32'(bus.out),       32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset busy",      32'(bus.busy),      32'd0);
    check("reset done",      32'(bus.done),      32'd0);
    check("reset status",    32'(bus.status),    32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].delay,
             vecs[i].st, vecs[i].lat, vecs[i].ov);

    // Reset pulsed during the third SEND cycle
    lk_delay = 0;
    @(negedge clk);
    bus.code_word = 12'o3210;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("midreset in_send_valid", 32'(bus.out_valid), 32'd1);
    check("midreset in_send_digit", 32'(bus.out),       32'd2);
    reset = 1'b0;
    #1;
    check("midreset out",       32'(bus.out),       32'd0);
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset busy",      32'(bus.busy),      32'd0);
    check("midreset done",      32'(bus.done),      32'd0);
    check("midreset status",    32'(bus.status),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("after_reset", 12'o3210, 0, 2'b01, 6, 4);

    // start held high across a whole operation
    lk_delay = 0;
    @(negedge clk);
    bus.code_word = 12'o3210;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("held first_latency", 32'(lat), 32'd6);
    check("held first_status",  32'(bus.status), 32'd1);
    @(posedge clk);
    #1;
    check("held idle_cycle_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check("held reaccept_busy",   32'(bus.busy),      32'd1);
    check("held reaccept_valid",  32'(bus.out_valid), 32'd1);
    check("held reaccept_digit0", 32'(bus.out),       32'd0);
    check("held reaccept_status", 32'(bus.status),    32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("held second_latency", 32'(lat), 32'd6);
    check("held second_status",  32'(bus.status), 32'd1);
    repeat (2) @(posedge clk);

    // Random operations against the reference model
    for (int k = 0; k < 16; k++) begin
      r_code  = ($urandom_range(0, 1) == 1) ? 12'o3210 : 12'($urandom);
      r_delay = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 17));
      ref_model(r_code, r_delay, r_st, r_lat, r_ov);
      run_op($sformatf("rand%0d", k), r_code, r_delay, r_st, r_lat, r_ov);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/code_sender.md
# code_sender

Transmit-side companion to the 4-digit sequential lock. It takes a 4-digit code word and drives the digits onto the lock's 3-bit code input, one per clock. It checks the lock's position indicator against the digit index, then waits a bounded time for the lock to report unlocked. On timeout it retries a configurable number of times and reports success, timeout, or desync to the controller.

## Interface
- `DIGIT_W`, default 3: width of one code digit.
- `MAX_WAIT`, default 15: cycles to wait for `locked`=0 after the last digit.
- `RETRIES`, default 2: extra attempts after a timeout; 0 means single attempt.
- `GAP`, default 12: idle cycles between a timeout and the next attempt. Must be ≥ 1.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request a send; sampled only in IDLE.
- `code_word` input 4*DIGIT_W: digit0 in [DIGIT_W-1:0], digit3 in the MSBs; latched on accepted `start`.
- `locked` input 1: lock status from the lock; 0 means unlocked.
- `selsw` input 2: lock position indicator (expected digit index).
- `out` output DIGIT_W: digit driven to the lock's code input.
- `out_valid` output 1: `out` carries a code digit this cycle.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when an operation finishes.
- `status` output 2: result, held until the next accepted `start`. 00 none, 01 success, 10 timeout, 11 desync.

## Operation
- States: IDLE, SEND, WAIT, GAP_WAIT, FINISH.
- IDLE:
  - `busy`=0, `out_valid`=0, `out`=0.
  - `start`=1 → latch `code_word`, clear `status` to 00, set digit index `idx`=0 and attempt counter `att`=0, go to SEND.
- SEND:
  - `out`=digit[idx], `out_valid`=1.
  - Every SEND cycle, compare `selsw` with `idx`:
    - Mismatch → `status`=11, go to FINISH. No retry.
    - Match with `idx`<3 → `idx`+1.
    - Match with `idx`=3 → clear wait counter `wcnt`, go to WAIT.
- WAIT:
  - `out_valid`=0.
  - `locked`=0 → `status`=01, go to FINISH. `locked` is checked before the timeout, so if both occur in the same cycle, success wins.
  - Otherwise `wcnt`+1.
  - `wcnt`=MAX_WAIT-1 with `locked` still 1 → timeout:
    - `att`<RETRIES → `att`+1, clear gap counter, go to GAP_WAIT.
    - Otherwise `status`=10, go to FINISH.
- GAP_WAIT:
  - `out_valid`=0.
  - Count GAP cycles, then `idx`=0 and go to SEND.
- FINISH:
  - `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored while `busy`=1. A `code_word` change mid-operation has no effect; the latched copy is used.
- `wcnt` is wide enough for MAX_WAIT and does not wrap. The gap counter is wide enough for GAP.
- `att` saturates at RETRIES.

## Timing
- All outputs are registered.
- Reset values: `out`=0, `out_valid`=0, `busy`=0, `done`=0, `status`=00, state IDLE, all counters 0.
- Reset assertion mid-operation: immediate return to reset values. No `done` is produced.
- `start` sampled high at edge N:
  - digit0 on `out` during cycle N+1, digit3 during N+4.
  - `out_valid` is high for exactly 4 consecutive cycles per attempt.
- The first WAIT cycle is N+5.
- Against a correct lock with the right code, `locked` drops in N+5 → `status`=01 and `done`=1 in N+6. Busy time is 6 cycles.
- Total timeout latency, first `start` to `done`: 1 + (RETRIES+1)·(4+MAX_WAIT) + RETRIES·GAP cycles.
- `status` becomes valid in the same cycle as `done` and holds afterwards.

## Test plan
- Correct code 0,1,2,3 (`code_word`=12'o3210) into a behavioural lock model:
  - `out` sequence 0,1,2,3 with `out_valid` high for 4 cycles.
  - `done` at start+6, `status`=01.
- Wrong code 12'o3213:
  - The lock enters WRONG, so `selsw`=00 while `idx`=1.
  - Desync detected in the second SEND cycle: `status`=11, `done` at start+3, no retry.
- `locked` held at 1 with `selsw` following `idx`, defaults:
  - 3 attempts, 12-cycle gaps, `status`=10.
  - `done` at start+1+3·19+2·12 = start+82.
- `locked` drops on the last WAIT cycle (`wcnt`=MAX_WAIT-1): `status`=01, no retry.
- `reset` pulsed low during the third SEND cycle:
  - Outputs return to reset values immediately.
  - A new `start` after release runs a clean first attempt.
- `start` held high across a completed operation: a new operation is accepted in the cycle after FINISH (IDLE), and no `start` is accepted while `busy`=1.
